// File: rtl/vend_mc_param_if.sv
// Coin/cancel inputs and dispense/change/status outputs of the vending controller.
interface vend_mc_param_if #(
    parameter int CREDIT_W = 6
);
    logic                i;
    logic                j;
    logic                cancel;
    logic                dout;
    logic                ret;
    logic                coin_rej;
    logic                busy;
    logic [CREDIT_W-1:0] credit;

    modport master (
        output i, j, cancel,
        input  dout, ret, coin_rej, busy, credit
    );

    modport slave (
        input  i, j, cancel,
        output dout, ret, coin_rej, busy, credit
    );
endinterface

// File: rtl/vend_mc_param.sv
// Parameterised coin-operated vending controller: accumulates credit from two
// coin inputs, dispenses when the price is reached, then pays change one unit
// per cycle. Cancel refunds accumulated credit as change without dispensing.
module vend_mc_param #(
    parameter int PRICE    = 15,
    parameter int COIN_I   = 5,
    parameter int COIN_J   = 10,
    parameter int CREDIT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    vend_mc_param_if.slave   bus
);

    // Largest value credit can momentarily reach: one unit short of the price
    // plus both coins landing in the same cycle.
    localparam int MAX_CREDIT = PRICE - 1 + COIN_I + COIN_J;

    if (MAX_CREDIT > (2 ** CREDIT_W) - 1) begin : g_cfg_err
        $error("vend_mc_param: CREDIT_W=%0d cannot hold %0d", CREDIT_W, MAX_CREDIT);
    end

    typedef enum logic [1:0] {
        COLLECT  = 2'b00,
        DISPENSE = 2'b01,
        CHANGE   = 2'b10,
        UNUSED   = 2'b11
    } state_t;

    state_t              ps;
    state_t              w_ns;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_change;
    logic                r_coin_rej;
    logic [CREDIT_W-1:0] w_credit_nx;
    logic [CREDIT_W-1:0] w_change_nx;
    logic [CREDIT_W-1:0] w_sum;
    logic                w_coin_rej_nx;
    logic                w_coin;

    // Next state, next credit/change and coin-reject decision for this edge.
    always_comb begin
        w_ns          = ps;
        w_credit_nx   = r_credit;
        w_change_nx   = r_change;
        w_coin_rej_nx = 1'b0;
        w_coin        = bus.i | bus.j;
        w_sum         = r_credit
                      + (bus.i ? CREDIT_W'(COIN_I) : '0)
                      + (bus.j ? CREDIT_W'(COIN_J) : '0);
        case (ps)
            COLLECT: begin
                // A refund wins over coins arriving in the same cycle; a
                // cancel with nothing to refund is a no-op and coins count.
                if (bus.cancel && (r_credit != '0)) begin
                    w_change_nx   = r_credit;
                    w_credit_nx   = '0;
                    w_ns          = CHANGE;
                    w_coin_rej_nx = w_coin;
                end else if (w_sum >= CREDIT_W'(PRICE)) begin
                    w_change_nx = w_sum - CREDIT_W'(PRICE);
                    w_credit_nx = '0;
                    w_ns        = DISPENSE;
                end else begin
                    w_credit_nx = w_sum;
                end
            end
            DISPENSE: begin
                w_coin_rej_nx = w_coin;
                w_ns          = (r_change != '0) ? CHANGE : COLLECT;
            end
            CHANGE: begin
                w_coin_rej_nx = w_coin;
                w_change_nx   = r_change - 1'b1;
                if (r_change <= CREDIT_W'(1)) begin
                    w_ns = COLLECT;
                end
            end
            default: begin
                // Unreachable encoding: drop any state and restart collecting.
                w_coin_rej_nx = w_coin;
                w_credit_nx   = '0;
                w_change_nx   = '0;
                w_ns          = COLLECT;
            end
        endcase
    end

    // State, credit, change and reject-pulse registers; reset aborts any payout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps         <= COLLECT;
            r_credit   <= '0;
            r_change   <= '0;
            r_coin_rej <= 1'b0;
        end else begin
            ps         <= w_ns;
            r_credit   <= w_credit_nx;
            r_change   <= w_change_nx;
            r_coin_rej <= w_coin_rej_nx;
        end
    end

    assign bus.dout     = (ps == DISPENSE);
    assign bus.ret      = (ps == CHANGE);
    assign bus.busy     = (ps != COLLECT);
    assign bus.coin_rej = r_coin_rej;
    assign bus.credit   = r_credit;

endmodule

// File: tb/tb_vend_mc_param.sv
// Bench for vend_mc_param: a schedule-based reference model plus directed
// scenarios with literal expectations.
module tb_vend_mc_param;

    localparam int PRICE    = 15;
    localparam int COIN_I   = 5;
    localparam int COIN_J   = 10;
    localparam int CREDIT_W = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    vend_mc_param_if #(.CREDIT_W(CREDIT_W)) bus ();

    vend_mc_param #(
        .PRICE   (PRICE),
        .COIN_I  (COIN_I),
        .COIN_J  (COIN_J),
        .CREDIT_W(CREDIT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_dout = 0;
    int cnt_ret  = 0;
    int cnt_rej  = 0;

    // Model: credit total, plus a list of upcoming output cycles
    // (1 = dispense cycle, 2 = change cycle); m_cur is the cycle now showing.
    int         m_credit = 0;
    logic [1:0] m_cur    = 2'b00;
    logic       m_rej    = 1'b0;
    logic [1:0] m_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advances on each clock edge; reset empties it at once.
    always @(posedge clk or negedge rst) begin : model
        int   sum;
        logic coin;
        if (!rst) begin
            m_credit = 0;
            m_cur    = 2'b00;
            m_rej    = 1'b0;
            m_q.delete();
        end else begin
            coin  = bus.i | bus.j;
            m_rej = 1'b0;
            if (m_cur == 2'b00) begin
                if (bus.cancel && m_credit > 0) begin
                    for (int k = 0; k < m_credit; k++) m_q.push_back(2'b10);
                    m_credit = 0;
                    m_rej    = coin;
                end else begin
                    sum = m_credit + (bus.i ? COIN_I : 0) + (bus.j ? COIN_J : 0);
                    if (sum >= PRICE) begin
                        m_q.push_back(2'b01);
                        for (int k = 0; k < sum - PRICE; k++) m_q.push_back(2'b10);
                        m_credit = 0;
                    end else begin
                        m_credit = sum;
                    end
                end
            end else begin
                m_rej = coin;
            end
            m_cur = (m_q.size() > 0) ? m_q.pop_front() : 2'b00;
        end
    end

    // Compare every DUT output against the model mid-cycle and tally pulses.
    always @(negedge clk) begin
        check("dout",     bus.dout,     m_cur == 2'b01);
        check("ret",      bus.ret,      m_cur == 2'b10);
        check("busy",     bus.busy,     m_cur != 2'b00);
        check("coin_rej", bus.coin_rej, m_rej);
        check("credit",   bus.credit,   m_credit);
        cnt_dout += int'(bus.dout);
        cnt_ret  += int'(bus.ret);
        cnt_rej  += int'(bus.coin_rej);
    end

    task automatic step(input logic vi, input logic vj, input logic vc);
        bus.i      = vi;
        bus.j      = vj;
        bus.cancel = vc;
        @(posedge clk);
        #1;
        bus.i      = 1'b0;
        bus.j      = 1'b0;
        bus.cancel = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clr_counts();
        cnt_dout = 0;
        cnt_ret  = 0;
        cnt_rej  = 0;
    endtask

    initial begin
        bus.i      = 1'b0;
        bus.j      = 1'b0;
        bus.cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   bus.busy,   0);
        check("rst_credit", bus.credit, 0);
        check("rst_ret",    bus.ret,    0);
        rst = 1'b1;

        // Three small coins: exact price, no change.
        clr_counts();
        step(1'b1, 1'b0, 1'b0);
        check("s1_credit5", bus.credit, 5);
        step(1'b1, 1'b0, 1'b0);
        check("s1_credit10", bus.credit, 10);
        step(1'b1, 1'b0, 1'b0);
        check("s1_dout", bus.dout, 1);
        check("s1_credit0", bus.credit, 0);
        idle(3);
        check("s1_ndout", cnt_dout, 1);
        check("s1_nret",  cnt_ret,  0);

        // Two large coins: dispense then five change cycles.
        clr_counts();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(8);
        check("s2_ndout", cnt_dout, 1);
        check("s2_nret",  cnt_ret,  5);
        check("s2_busy",  bus.busy, 0);

        // Both coins together reach the price exactly.
        clr_counts();
        step(1'b1, 1'b1, 1'b0);
        check("s3_dout", bus.dout, 1);
        idle(4);
        check("s3_ndout", cnt_dout, 1);
        check("s3_nret",  cnt_ret,  0);

        // Cancel with a coin in the same cycle: refund, coin rejected.
        clr_counts();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        idle(8);
        check("s4_nret",  cnt_ret,  5);
        check("s4_nrej",  cnt_rej,  1);
        check("s4_ndout", cnt_dout, 0);

        // Coin during the dispense cycle is rejected and not credited.
        clr_counts();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(3);
        check("s5_nrej",   cnt_rej,    1);
        check("s5_credit", bus.credit, 0);

        // Coins during change payout: each offending cycle rejects once.
        clr_counts();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(6);
        check("s6_nrej", cnt_rej, 2);
        check("s6_nret", cnt_ret, 5);

        // Cancel with zero credit is ignored and same-cycle coins still count.
        clr_counts();
        step(1'b0, 1'b0, 1'b1);
        check("s7_busy", bus.busy, 0);
        step(1'b1, 1'b0, 1'b1);
        check("s7_credit5", bus.credit, 5);
        step(1'b0, 1'b0, 1'b1);
        check("s7_ret", bus.ret, 1);
        idle(7);
        check("s7_nret", cnt_ret, 5);
        check("s7_nrej", cnt_rej, 0);

        // Reset during the second change cycle aborts the payout.
        clr_counts();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("s8_ret_pre", bus.ret, 1);
        #2 rst = 1'b0;
        #1;
        check("s8_ret_rst",  bus.ret,  0);
        check("s8_busy_rst", bus.busy, 0);
        check("s8_dout_rst", bus.dout, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        clr_counts();
        idle(6);
        check("s8_nret_after", cnt_ret, 0);
        step(1'b1, 1'b0, 1'b0);
        check("s8_credit5", bus.credit, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
